// File: rtl/timer_pkg.sv
// Shared types and bit positions for the APB timer control unit.
package timer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;
endpackage

// File: rtl/timer_prescaler.sv
// Count-enable divider: one cnt_tick every (2 << cks) cycles while running.
module timer_prescaler (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       run,
  input  logic       restart,
  input  logic [1:0] cks,
  output logic       cnt_tick
);
  logic [3:0] div;
  logic [4:0] n_m1;

  assign n_m1 = (5'd2 << cks) - 5'd1;

  // >= lets a mid-run CKS decrease tick immediately instead of wrapping through 15
  assign cnt_tick = PRESETn & run & ({1'b0, div} >= n_m1);

  always_ff @(posedge PCLK) begin
    if (!PRESETn)              div <= '0;
    else if (restart || !run)  div <= '0;
    else if (cnt_tick)         div <= '0;
    else                       div <= div + 4'd1;
  end
endmodule

// File: rtl/timer_ctrl.sv
// Timer control unit: TCR/TDR/TSR registers, IDLE/LOAD/RUN sequencing, prescaler and irq.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] TDR_IN,
  input  logic             tdr_wr,
  input  logic [7:0]       TCR_IN,
  input  logic             tcr_wr,
  input  logic [1:0]       tsr_clr,
  input  logic [1:0]       irq_mask,
  input  logic             flag_ovf,
  input  logic             flag_udf,
  output logic             cnt_load,
  output logic [WIDTH-1:0] load_val,
  output logic             cnt_tick,
  output logic             cnt_dir,
  output logic [7:0]       TCR_Q,
  output logic [1:0]       TSR,
  output logic             irq
);
  state_e           state;
  logic             tcr_dir, tcr_en;
  logic [1:0]       tcr_cks;
  logic [WIDTH-1:0] tdr;
  logic [1:0]       tsr;
  logic             cnt_load_q;
  logic             go_load, go_run, go_idle, restart;
  logic             unused_tcr_bits;

  assign unused_tcr_bits = ^{TCR_IN[6], TCR_IN[3:2]};

  assign go_load = tcr_wr & TCR_IN[TCR_LOAD] & (state != ST_LOAD);
  assign go_run  = tcr_wr & ~TCR_IN[TCR_LOAD] & TCR_IN[TCR_EN] & (state == ST_IDLE);
  assign go_idle = tcr_wr & ~TCR_IN[TCR_LOAD] & ~TCR_IN[TCR_EN] & (state == ST_RUN);
  assign restart = go_load | go_run | ((state == ST_LOAD) & tcr_en);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      tcr_dir    <= 1'b0;
      tcr_en     <= 1'b0;
      tcr_cks    <= 2'b00;
      tdr        <= '0;
      tsr        <= 2'b00;
      cnt_load_q <= 1'b0;
    end else begin
      if (tcr_wr) begin
        tcr_dir <= TCR_IN[TCR_DIR];
        tcr_en  <= TCR_IN[TCR_EN];
        tcr_cks <= TCR_IN[TCR_CKS_HI:TCR_CKS_LO];
      end
      if (tdr_wr) tdr <= TDR_IN;
      // set wins over a same-cycle clear
      tsr        <= (tsr & ~tsr_clr) | {flag_udf, flag_ovf};
      cnt_load_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_load) begin
            state      <= ST_LOAD;
            cnt_load_q <= 1'b1;
          end else if (go_run) begin
            state <= ST_RUN;
          end
        end
        ST_LOAD: state <= tcr_en ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (go_load) begin
            state      <= ST_LOAD;
            cnt_load_q <= 1'b1;
          end else if (go_idle) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  timer_prescaler u_prescaler (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .run     (state == ST_RUN),
    .restart (restart),
    .cks     (tcr_cks),
    .cnt_tick(cnt_tick)
  );

  // a reset asserted mid-LOAD suppresses the load in that same cycle
  assign cnt_load = cnt_load_q & PRESETn;
  assign load_val = tdr;
  assign cnt_dir  = tcr_dir;
  assign TCR_Q    = {2'b00, tcr_dir, tcr_en, 2'b00, tcr_cks};
  assign TSR      = tsr;
  assign irq      = |(tsr & irq_mask);
endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: expected load/tick cycles queued at stimulus time.
module tb_timer_ctrl;
  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [7:0] TDR_IN;
  logic       tdr_wr;
  logic [7:0] TCR_IN;
  logic       tcr_wr;
  logic [1:0] tsr_clr, irq_mask;
  logic       flag_ovf, flag_udf;
  logic       cnt_load, cnt_tick, cnt_dir, irq;
  logic [7:0] load_val, TCR_Q;
  logic [1:0] TSR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  int tick_q[$];
  int load_cyc_q[$];
  logic [7:0] load_val_q[$];
  int base_l, base_s;

  timer_ctrl #(.WIDTH(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .TDR_IN(TDR_IN), .tdr_wr(tdr_wr),
    .TCR_IN(TCR_IN), .tcr_wr(tcr_wr), .tsr_clr(tsr_clr), .irq_mask(irq_mask),
    .flag_ovf(flag_ovf), .flag_udf(flag_udf), .cnt_load(cnt_load),
    .load_val(load_val), .cnt_tick(cnt_tick), .cnt_dir(cnt_dir),
    .TCR_Q(TCR_Q), .TSR(TSR), .irq(irq)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // scoreboard: every observed load/tick must match the head of its queue
  always @(negedge PCLK) begin
    if (mon_en) begin
      total++;
      if (cnt_load && cnt_tick) begin
        bad++;
        $display("FAIL load_tick_overlap cyc=%0d load=%b tick=%b required not both", cyc, cnt_load, cnt_tick);
      end
      if (cnt_tick) begin
        total++;
        if (tick_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_tick cyc=%0d got tick required none", cyc);
        end else begin
          int exp_c;
          exp_c = tick_q.pop_front();
          if (cyc !== exp_c) begin
            bad++;
            $display("FAIL tick_cycle got=%0d required=%0d", cyc, exp_c);
          end
        end
      end
      if (cnt_load) begin
        total++;
        if (load_cyc_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_load cyc=%0d load_val=%h required none", cyc, load_val);
        end else begin
          int exp_c;
          logic [7:0] exp_v;
          exp_c = load_cyc_q.pop_front();
          exp_v = load_val_q.pop_front();
          if (cyc !== exp_c || load_val !== exp_v) begin
            bad++;
            $display("FAIL load cyc=%0d val=%h required cyc=%0d val=%h", cyc, load_val, exp_c, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_empty(input string name);
    total++;
    if (tick_q.size() != 0 || load_cyc_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending ticks_left=%0d loads_left=%0d required 0", name, tick_q.size(), load_cyc_q.size());
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; TDR_IN = '0; tdr_wr = 0; TCR_IN = '0; tcr_wr = 0;
    tsr_clr = '0; irq_mask = '0; flag_ovf = 0; flag_udf = 0;
    repeat (3) step();
    total++;
    if ({cnt_load, cnt_tick, cnt_dir, irq, load_val, TCR_Q, TSR} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0", {cnt_load, cnt_tick, cnt_dir, irq, load_val, TCR_Q, TSR});
    end
    PRESETn = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_basic();
    tdr_wr = 1; TDR_IN = 8'h80;
    step();
    tdr_wr = 0;
    tcr_wr = 1; TCR_IN = 8'h90;
    base_l = cyc + 1;
    load_cyc_q.push_back(base_l); load_val_q.push_back(8'h80);
    for (int k = 1; k <= 5; k++) tick_q.push_back(base_l + 2 * k);
    step();
    tcr_wr = 0;
    total++;
    if (load_val !== 8'h80) begin bad++; $display("FAIL basic_load_val got=%h required=80", load_val); end
    total++;
    if (TCR_Q !== 8'h10) begin bad++; $display("FAIL basic_tcr_q got=%h required=10", TCR_Q); end
    wait_until(base_l + 10);
  endtask

  task automatic test_cks_change();
    tcr_wr = 1; TCR_IN = 8'h13;
    tick_q.push_back(base_l + 26);
    tick_q.push_back(base_l + 42);
    step();
    tcr_wr = 0;
    total++;
    if (TCR_Q !== 8'h13) begin bad++; $display("FAIL cks_tcr_q got=%h required=13", TCR_Q); end
    wait_until(base_l + 53);
    tcr_wr = 1; TCR_IN = 8'h10;
    for (int t = 54; t <= 60; t += 2) tick_q.push_back(base_l + t);
    step();
    tcr_wr = 0;
    wait_until(base_l + 60);
  endtask

  task automatic test_stop_resume();
    tcr_wr = 1; TCR_IN = 8'h00;
    step();
    tcr_wr = 0;
    total++;
    if (TCR_Q !== 8'h00) begin bad++; $display("FAIL stop_tcr_q got=%h required=00", TCR_Q); end
    repeat (20) step();
    check_empty("stop");
    base_s = cyc;
    tcr_wr = 1; TCR_IN = 8'h30;
    for (int k = 1; k <= 14; k++) tick_q.push_back(base_s + 2 * k);
    step();
    tcr_wr = 0;
    total++;
    if (cnt_dir !== 1'b1) begin bad++; $display("FAIL resume_dir got=%b required=1", cnt_dir); end
    total++;
    if (TCR_Q !== 8'h30) begin bad++; $display("FAIL resume_tcr_q got=%h required=30", TCR_Q); end
    total++;
    if (cnt_load !== 1'b0) begin bad++; $display("FAIL resume_no_load got=%b required=0", cnt_load); end
  endtask

  task automatic test_flags();
    irq_mask = 2'b01;
    flag_ovf = 1;
    total++;
    if (TSR !== 2'b00 || irq !== 1'b0) begin bad++; $display("FAIL flag_pre got tsr=%b irq=%b required 00/0", TSR, irq); end
    step();
    flag_ovf = 0;
    total++;
    if (TSR !== 2'b01 || irq !== 1'b1) begin bad++; $display("FAIL flag_ovf got tsr=%b irq=%b required 01/1", TSR, irq); end
    flag_udf = 1; tsr_clr = 2'b10;
    step();
    flag_udf = 0; tsr_clr = 2'b00;
    total++;
    if (TSR !== 2'b11) begin bad++; $display("FAIL flag_set_wins got=%b required=11", TSR); end
    tsr_clr = 2'b11;
    step();
    tsr_clr = 2'b00;
    total++;
    if (TSR !== 2'b00 || irq !== 1'b0) begin bad++; $display("FAIL flag_clear got tsr=%b irq=%b required 00/0", TSR, irq); end
    flag_udf = 1;
    step();
    flag_udf = 0;
    total++;
    if (TSR !== 2'b10 || irq !== 1'b0) begin bad++; $display("FAIL flag_udf_masked got tsr=%b irq=%b required 10/0", TSR, irq); end
    irq_mask = 2'b10;
    #1;
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL flag_udf_unmasked got=%b required=1", irq); end
    flag_ovf = 1;
    step();
    flag_ovf = 0;
    total++;
    if (TSR !== 2'b11) begin bad++; $display("FAIL flag_both got=%b required=11", TSR); end
  endtask

  task automatic test_reset_mid_run();
    wait_until(base_s + 30);
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    total++;
    if ({cnt_load, cnt_tick, cnt_dir, irq, load_val, TCR_Q, TSR} !== 22'd0) begin
      bad++;
      $display("FAIL midrun_reset got=%h required=0", {cnt_load, cnt_tick, cnt_dir, irq, load_val, TCR_Q, TSR});
    end
    repeat (12) step();
    check_empty("midrun_reset");
  endtask

  task automatic test_same_cycle_load();
    tdr_wr = 1; TDR_IN = 8'h05;
    tcr_wr = 1; TCR_IN = 8'h80;
    load_cyc_q.push_back(cyc + 1); load_val_q.push_back(8'h05);
    step();
    tdr_wr = 0; tcr_wr = 0;
    total++;
    if (load_val !== 8'h05) begin bad++; $display("FAIL same_cycle_val got=%h required=05", load_val); end
    total++;
    if (TCR_Q !== 8'h00) begin bad++; $display("FAIL same_cycle_tcr_q got=%h required=00", TCR_Q); end
    repeat (20) step();
    check_empty("same_cycle");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cks_change();
    test_stop_resume();
    test_flags();
    test_reset_mid_run();
    test_same_cycle_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
